// File: rtl/pwm_pkg.sv
// Shared PWM types and default sizing.
// Imported by pwm and pwm_thres_buf.
package pwm_pkg;

  localparam int PWM_WIDTH = 16;
  localparam int NUM_PWM   = 4;

  typedef logic [PWM_WIDTH-1:0]       thres_t;
  typedef logic [$clog2(NUM_PWM)-1:0] chan_id_t;

endpackage

// File: rtl/pwm_thres_bank.sv
// Threshold register array: one write port,
// a parallel load and an unregistered read-all.
module pwm_thres_bank
  import pwm_pkg::*;
#(
  parameter int W  = PWM_WIDTH,
  parameter int N  = NUM_PWM,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IW-1:0]       id,
  input  logic [W-1:0]        data,
  input  logic                load,
  input  logic [N-1:0][W-1:0] load_data,
  output logic [N-1:0][W-1:0] rd_data
);

  logic [N-1:0][W-1:0] mem_q;
  logic [N-1:0][W-1:0] mem_d;

  // Parallel load wins; ids past the last channel are dropped
  always_comb begin
    mem_d = mem_q;
    if (load) begin
      mem_d = load_data;
    end else if (we && (int'(id) < N)) begin
      mem_d[id] = data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/pwm_thres_buf.sv
// Double-buffered PWM thresholds; a commit is
// published atomically on the next latch_mem.
module pwm_thres_buf
  import pwm_pkg::*;
#(
  parameter int pwm_width = PWM_WIDTH,
  parameter int num_pwm   = NUM_PWM,
  localparam int IW = (num_pwm > 1) ? $clog2(num_pwm) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [IW-1:0]        wr_id,
  input  logic [pwm_width-1:0] wr_data,
  input  logic                 commit,
  output logic                 commit_pending,
  output logic                 swap_done,
  input  logic [IW-1:0]        thres_id,
  output logic [pwm_width-1:0] thres,
  input  logic                 latch_mem
);

  logic pend_q, pend_d;
  logic done_q, done_d;
  logic [pwm_width-1:0] thres_q, thres_d;
  logic wr_fire, swap;

  logic [num_pwm-1:0][pwm_width-1:0] sh_rd;
  logic [num_pwm-1:0][pwm_width-1:0] act_rd;

  // Shadow is frozen from commit until the swap
  assign wr_ready = ~pend_q & ~rst;
  assign wr_fire  = wr_valid & wr_ready;
  assign swap     = latch_mem & pend_q;

  always_comb begin
    pend_d = pend_q;
    if (swap) begin
      pend_d = 1'b0;
    end else if (commit) begin
      pend_d = 1'b1;
    end
    done_d  = swap;
    thres_d = '0;
    // Boundary read sees the new frame
    if (int'(thres_id) < num_pwm) begin
      thres_d = swap ? sh_rd[thres_id]
                     : act_rd[thres_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      thres_q <= '0;
    end else begin
      pend_q  <= pend_d;
      done_q  <= done_d;
      thres_q <= thres_d;
    end
  end

  assign commit_pending = pend_q;
  assign swap_done      = done_q;
  assign thres          = thres_q;

  pwm_thres_bank #(
    .W (pwm_width),
    .N (num_pwm),
    .IW(IW)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_fire),
    .id       (wr_id),
    .data     (wr_data),
    .load     (1'b0),
    .load_data('0),
    .rd_data  (sh_rd)
  );

  pwm_thres_bank #(
    .W (pwm_width),
    .N (num_pwm),
    .IW(IW)
  ) u_active (
    .clk      (clk),
    .rst      (rst),
    .we       (1'b0),
    .id       ('0),
    .data     ('0),
    .load     (swap),
    .load_data(sh_rd),
    .rd_data  (act_rd)
  );

endmodule

// File: tb/tb_pwm_thres_buf.sv
// Bench for pwm_thres_buf: directed plan plus
// random traffic against a frame-level model.
module tb_pwm_thres_buf;
  import pwm_pkg::*;

  localparam int W  = PWM_WIDTH;
  localparam int N  = NUM_PWM;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] wr_id = '0;
  logic [W-1:0]  wr_data = '0;
  logic          commit = 1'b0;
  logic          commit_pending;
  logic          swap_done;
  logic [IW-1:0] thres_id = '0;
  logic [W-1:0]  thres;
  logic          latch_mem = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_sh [N];
  logic [W-1:0] m_act[N];
  bit           m_pend;

  always #5 clk = ~clk;

  pwm_thres_buf dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_id         (wr_id),
    .wr_data       (wr_data),
    .commit        (commit),
    .commit_pending(commit_pending),
    .swap_done     (swap_done),
    .thres_id      (thres_id),
    .thres         (thres),
    .latch_mem     (latch_mem)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, check ready, advance model and DUT, check outputs
  task automatic cyc(input bit r, input bit v,
                     input int id, input int d,
                     input bit c, input bit l,
                     input int tid);
    bit           rdy, sw;
    logic [W-1:0] et;
    rst       = r;
    wr_valid  = v;
    wr_id     = id[IW-1:0];
    wr_data   = d[W-1:0];
    commit    = c;
    latch_mem = l;
    thres_id  = tid[IW-1:0];
    #1;
    rdy = !m_pend && !r;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, rdy});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i]  = '0;
        m_act[i] = '0;
      end
      m_pend = 1'b0;
      sw     = 1'b0;
      et     = '0;
    end else begin
      sw = l && m_pend;
      et = '0;
      if (tid < N) et = sw ? m_sh[tid] : m_act[tid];
      if (v && rdy && id < N) m_sh[id] = d[W-1:0];
      if (sw) begin
        for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
        m_pend = 1'b0;
      end else if (c) begin
        m_pend = 1'b1;
      end
    end
    #1;
    chk("thres", {16'd0, thres}, {16'd0, et});
    chk("swap_done", {31'd0, swap_done}, {31'd0, sw});
    chk("commit_pending", {31'd0, commit_pending}, {31'd0, m_pend});
  endtask

  task automatic idle(input int tid);
    cyc(0, 0, 0, 0, 0, 0, tid);
  endtask

  task automatic wr(input int id, input int d);
    cyc(0, 1, id, d, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_pend = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // 1: reset state
    for (int i = 0; i < N; i++) begin
      idle(i);
      chk("rst_read", {16'd0, thres}, 32'h0);
    end
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);

    // 2: writes without commit do not reach active
    for (int i = 0; i < N; i++) wr(i, (i + 1) * 32'h1000);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("nocommit_read", {16'd0, thres}, 32'h0);
    chk("nocommit_done", {31'd0, swap_done}, 32'd0);

    // 3: commit then boundary, bypass on id 0
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle(0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("bypass", {16'd0, thres}, 32'h1000);
    chk("swap_pulse", {31'd0, swap_done}, 32'd1);
    chk("pend_clear", {31'd0, commit_pending}, 32'd0);
    idle(1);
    chk("swap_pulse_once", {31'd0, swap_done}, 32'd0);
    chk("rd1", {16'd0, thres}, 32'h2000);
    idle(2);
    chk("rd2", {16'd0, thres}, 32'h3000);
    idle(3);
    chk("rd3", {16'd0, thres}, 32'h4000);

    // 4: write held off while pending, lands in shadow only
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 2, 'hBEEF, 0, 0, 2);
    cyc(0, 1, 2, 'hBEEF, 0, 1, 2);
    chk("held_swap", {31'd0, swap_done}, 32'd1);
    cyc(0, 1, 2, 'hBEEF, 0, 0, 2);
    idle(2);
    chk("shadow_only", {16'd0, thres}, 32'h3000);
    cyc(0, 0, 0, 0, 1, 0, 2);
    cyc(0, 0, 0, 0, 0, 1, 2);
    idle(2);
    chk("second_commit", {16'd0, thres}, 32'hBEEF);

    // 5: commit and latch together arm only
    wr(0, 'h5555);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("same_cyc_pend", {31'd0, commit_pending}, 32'd1);
    chk("same_cyc_noswap", {31'd0, swap_done}, 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("late_swap", {16'd0, thres}, 32'h5555);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("double_latch", {31'd0, swap_done}, 32'd0);

    // 6: reset discards an armed commit
    wr(1, 'h7777);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pend", {31'd0, commit_pending}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("rst_noswap", {31'd0, swap_done}, 32'd0);
    chk("rst_clear", {16'd0, thres}, 32'h0);
    for (int i = 0; i < N; i++) idle(i);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 1) == 1),
          $urandom_range(0, N - 1),
          $urandom_range(0, 65535),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0),
          $urandom_range(0, N - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
